// File: rtl/io_input_reader_pkg.sv
// io_input_reader_pkg: shared widths and IO read address map for the button reader
package io_input_reader_pkg;

    localparam int WIDTH = 32;
    localparam int NUM_INPUTS = 16;

    localparam logic [8:0] IO_BTN_BASE  = 9'h101;
    localparam logic [8:0] IO_BTN_ALL   = 9'h111;
    localparam logic [8:0] IO_BTN_EDGES = 9'h112;

    // True for the sixteen single-button addresses IO_BTN_BASE..IO_BTN_BASE+15
    function automatic logic is_btn_addr(input logic [8:0] addr);
        return addr >= IO_BTN_BASE && addr <= IO_BTN_BASE + 9'd15;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: one-bit sampled debounce with sticky rising-edge flag
module input_debouncer #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic clock,
    input  logic active_low_reset,
    input  logic sample_tick,
    input  logic sync_bit,
    input  logic clear_flag,
    output logic level,
    output logic edge_flag
);

    logic [STABLE_SAMPLES-1:0] history;
    logic [STABLE_SAMPLES-1:0] next_history;
    logic rise;

    assign next_history = {history[STABLE_SAMPLES-2:0], sync_bit};
    assign rise = sample_tick && (&next_history) && !level;

    // Shift history on each tick, accept a level once every sample agrees; a new edge beats a clear
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            history   <= '0;
            level     <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            if (sample_tick) begin
                history <= next_history;
                if (&next_history)
                    level <= 1'b1;
                else if (~|next_history)
                    level <= 1'b0;
            end
            edge_flag <= rise | (edge_flag & ~clear_flag);
        end
    end

endmodule

// File: rtl/io_input_reader.sv
// io_input_reader: synchronised, debounced button inputs readable over the IO bus
module io_input_reader
    import io_input_reader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STABLE_SAMPLES  = 3
) (
    input  logic                  clock,
    input  logic                  active_low_reset,
    input  logic                  io_read_enable,
    input  logic [15:0]           memory_address,
    input  logic [NUM_INPUTS-1:0] buttons,
    output logic [WIDTH-1:0]      read_data,
    output logic                  read_valid
);

    localparam int PW = $clog2(DEBOUNCE_CYCLES);

    logic [PW-1:0]         prescaler;
    logic                  sample_tick;
    logic [NUM_INPUTS-1:0] sync_1;
    logic [NUM_INPUTS-1:0] sync_2;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] edge_flag;
    logic [8:0]            addr;
    logic [3:0]            btn_index;
    logic                  clear_flags;
    logic [WIDTH-1:0]      read_mux;
    logic                  unused_address_bits;

    assign addr                = memory_address[8:0];
    assign unused_address_bits = ^memory_address[15:9];
    assign btn_index           = 4'(addr - IO_BTN_BASE);
    assign sample_tick         = prescaler == PW'(DEBOUNCE_CYCLES - 1);
    assign clear_flags         = io_read_enable && addr == IO_BTN_EDGES;

    // Shared prescaler paces every debouncer's sampling
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset)
            prescaler <= '0;
        else
            prescaler <= sample_tick ? '0 : prescaler + 1'b1;
    end

    // Two-flop synchroniser on the raw asynchronous inputs
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= buttons;
            sync_2 <= sync_1;
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_debounce
        input_debouncer #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_debouncer (
            .clock           (clock),
            .active_low_reset(active_low_reset),
            .sample_tick     (sample_tick),
            .sync_bit        (sync_2[g]),
            .clear_flag      (clear_flags),
            .level           (level[g]),
            .edge_flag       (edge_flag[g])
        );
    end

    // Address decode of the pre-edge levels and flags
    always_comb begin
        read_mux = '0;
        if (is_btn_addr(addr))
            read_mux[0] = level[btn_index];
        else if (addr == IO_BTN_ALL)
            read_mux[NUM_INPUTS-1:0] = level;
        else if (addr == IO_BTN_EDGES)
            read_mux[NUM_INPUTS-1:0] = edge_flag;
    end

    // Register the read result; data holds until the next read completes
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= io_read_enable;
            if (io_read_enable)
                read_data <= read_mux;
        end
    end

endmodule
